// File: rtl/led_sequencer_if.sv
// Control/status bundle between the rate-tick source and the LED sequencer.
// The master drives the tick and controls; the slave returns the LED pattern and cycle status.
interface led_sequencer_if #(
  parameter int NB_LEDS = 4,
  parameter int NB_CYC  = 8
);
  logic               i_valid;
  logic               i_enable;
  logic [1:0]         i_mode;
  logic               i_clr;
  logic [NB_LEDS-1:0] o_led;
  logic               o_wrap;
  logic               o_dir;
  logic [NB_CYC-1:0]  o_cycles;

  modport master (
    output i_valid, i_enable, i_mode, i_clr,
    input  o_led, o_wrap, o_dir, o_cycles
  );

  modport slave (
    input  i_valid, i_enable, i_mode, i_clr,
    output o_led, o_wrap, o_dir, o_cycles
  );
endinterface

// File: rtl/led_sequencer.sv
// Tick-driven LED pattern sequencer: rotate left/right, ping-pong, blink,
// with a wrap pulse per completed pattern cycle and a saturating cycle counter.
package led_sequencer_pkg;
  typedef enum logic [2:0] {
    OP_HOLD, OP_SEED_ONE, OP_SEED_ALL, OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_INV
  } led_op_e;
endpackage

// Next value of one LED bit, given the bit itself and its two ring neighbours.
module led_sequencer_lane
  import led_sequencer_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int NB_LEDS = 4
) (
  input  led_op_e op,
  input  logic    cur,
  input  logic    lo,   // bit IDX-1, wrapping to MSB at IDX=0
  input  logic    hi,   // bit IDX+1, wrapping to bit 0 at MSB
  output logic    nxt
);
  always_comb begin
    nxt = cur;
    case (op)
      OP_SEED_ONE: nxt = (IDX == 0);
      OP_SEED_ALL: nxt = 1'b1;
      OP_ROL:      nxt = lo;
      OP_ROR:      nxt = hi;
      OP_SHL:      nxt = (IDX == 0) ? 1'b0 : lo;
      OP_SHR:      nxt = (IDX == NB_LEDS-1) ? 1'b0 : hi;
      OP_INV:      nxt = ~cur;
      default:     nxt = cur;
    endcase
  end
endmodule

module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_CYC  = 8
) (
  input  logic           clk,
  input  logic           i_rst,
  led_sequencer_if.slave bus
);
  typedef enum logic [2:0] { IDLE, SHL, SHR, BNC, BLK } state_e;

  localparam logic [NB_LEDS-1:0] SEED_ONE = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] ALL_ONES = '1;
  localparam logic [NB_CYC-1:0]  CYC_MAX  = '1;

  state_e             state, target;
  logic               valid_q;
  logic               tick;
  logic [NB_LEDS-1:0] led_q, led_nxt;
  logic               wrap_q, dir_q;
  logic [NB_CYC-1:0]  cyc_q;
  led_op_e            op;

  // valid_q tracks i_valid even while disabled, so re-enabling under a high level gives no tick
  assign tick = bus.i_valid & ~valid_q & bus.i_enable;

  always_comb begin
    target = SHL;
    case (bus.i_mode)
      2'b00:   target = SHL;
      2'b01:   target = SHR;
      2'b10:   target = BNC;
      default: target = BLK;
    endcase
  end

  always_comb begin
    op = OP_HOLD;
    if (tick) begin
      if (state != target) op = (target == BLK) ? OP_SEED_ALL : OP_SEED_ONE;
      else begin
        case (state)
          SHL:     op = OP_ROL;
          SHR:     op = OP_ROR;
          BNC:     op = dir_q ? OP_SHR : OP_SHL;
          BLK:     op = OP_INV;
          default: op = OP_HOLD;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NB_LEDS; i++) begin : g_lane
    led_sequencer_lane #(.IDX(i), .NB_LEDS(NB_LEDS)) u_lane (
      .op  (op),
      .cur (led_q[i]),
      .lo  (led_q[(i+NB_LEDS-1)%NB_LEDS]),
      .hi  (led_q[(i+1)%NB_LEDS]),
      .nxt (led_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q <= 1'b0;
      state   <= IDLE;
      led_q   <= SEED_ONE;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      valid_q <= bus.i_valid;
      wrap_q  <= 1'b0;
      if (tick) begin
        led_q <= led_nxt;
        if (state != target) begin
          state <= target;
          dir_q <= 1'b0;
        end else begin
          case (state)
            SHL: wrap_q <= led_q[NB_LEDS-1];
            SHR: wrap_q <= led_q[0];
            BNC: begin
              if (!dir_q) begin
                if (led_nxt[NB_LEDS-1]) dir_q <= 1'b1;
              end else if (led_nxt == SEED_ONE) begin
                dir_q  <= 1'b0;
                wrap_q <= 1'b1;
              end
            end
            BLK:     wrap_q <= (led_nxt == ALL_ONES);
            default: wrap_q <= 1'b0;
          endcase
        end
      end
      // clear beats the increment; the count holds while disabled
      if (bus.i_clr)                                      cyc_q <= '0;
      else if (bus.i_enable && wrap_q && cyc_q != CYC_MAX) cyc_q <= cyc_q + NB_CYC'(1);
    end
  end

  assign bus.o_led    = led_q;
  assign bus.o_wrap   = wrap_q;
  assign bus.o_dir    = dir_q;
  assign bus.o_cycles = cyc_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a vector table for the pattern modes plus
// hand sequences for reset, held valid, disable, and counter saturation/clear.
module tb_led_sequencer;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  led_sequencer_if #(.NB_LEDS(4), .NB_CYC(8)) ifc ();
  led_sequencer_if #(.NB_LEDS(4), .NB_CYC(2)) ifc2 ();

  // the narrow-counter instance sees the same stimulus
  assign ifc2.i_valid  = ifc.i_valid;
  assign ifc2.i_enable = ifc.i_enable;
  assign ifc2.i_mode   = ifc.i_mode;
  assign ifc2.i_clr    = ifc.i_clr;

  led_sequencer #(.NB_LEDS(4), .NB_CYC(8)) u_dut  (.clk(clk), .i_rst(rst_n), .bus(ifc));
  led_sequencer #(.NB_LEDS(4), .NB_CYC(2)) u_dut2 (.clk(clk), .i_rst(rst_n), .bus(ifc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] led;
    logic       wrap;
    logic       dir;
    logic [7:0] cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc_edge();
    @(posedge clk);
    #1;
  endtask

  // one rising edge of i_valid: outputs sampled after the tick edge, then valid drops
  task automatic do_tick(output logic [3:0] led, output logic wrap, output logic dir);
    ifc.i_valid = 1'b1;
    cyc_edge();
    led  = ifc.o_led;
    wrap = ifc.o_wrap;
    dir  = ifc.o_dir;
    ifc.i_valid = 1'b0;
    cyc_edge();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    check("rst_async_led", 32'(ifc.o_led), 32'h1);
    check("rst_async_cyc", 32'(ifc.o_cycles), 32'h0);
    check("rst_async_wrap", 32'(ifc.o_wrap), 32'h0);
    check("rst_async_dir", 32'(ifc.o_dir), 32'h0);
    cyc_edge();
    rst_n = 1'b1;
    cyc_edge();
  endtask

  vec_t       tbl[20];
  int         exp6[5];
  logic [3:0] led;
  logic       wrap, dir;

  initial begin
    tbl = '{
      '{2'd0, 4'b0001, 1'b0, 1'b0, 8'd0},  // seed from IDLE
      '{2'd0, 4'b0010, 1'b0, 1'b0, 8'd0},
      '{2'd0, 4'b0100, 1'b0, 1'b0, 8'd0},
      '{2'd0, 4'b1000, 1'b0, 1'b0, 8'd0},
      '{2'd0, 4'b0001, 1'b1, 1'b0, 8'd1},
      '{2'd0, 4'b0010, 1'b0, 1'b0, 8'd1},
      '{2'd2, 4'b0001, 1'b0, 1'b0, 8'd1},  // switch to ping-pong: reseed
      '{2'd2, 4'b0010, 1'b0, 1'b0, 8'd1},
      '{2'd2, 4'b0100, 1'b0, 1'b0, 8'd1},
      '{2'd2, 4'b1000, 1'b0, 1'b1, 8'd1},
      '{2'd2, 4'b0100, 1'b0, 1'b1, 8'd1},
      '{2'd2, 4'b0010, 1'b0, 1'b1, 8'd1},
      '{2'd2, 4'b0001, 1'b1, 1'b0, 8'd2},
      '{2'd2, 4'b0010, 1'b0, 1'b0, 8'd2},
      '{2'd0, 4'b0001, 1'b0, 1'b0, 8'd2},
      '{2'd0, 4'b0010, 1'b0, 1'b0, 8'd2},
      '{2'd0, 4'b0100, 1'b0, 1'b0, 8'd2},
      '{2'd3, 4'b1111, 1'b0, 1'b0, 8'd2},  // blink mid-sequence
      '{2'd3, 4'b0000, 1'b0, 1'b0, 8'd2},
      '{2'd3, 4'b1111, 1'b1, 1'b0, 8'd3}
    };
    exp6 = '{1, 2, 3, 3, 3};

    rst_n        = 1'b1;
    ifc.i_valid  = 1'b0;
    ifc.i_enable = 1'b1;
    ifc.i_mode   = 2'd0;
    ifc.i_clr    = 1'b0;
    #1;
    reset_pulse();

    foreach (tbl[i]) begin
      ifc.i_mode = tbl[i].mode;
      do_tick(led, wrap, dir);
      check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
      check($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
      check($sformatf("tbl%0d_dir", i), 32'(dir), 32'(tbl[i].dir));
      check($sformatf("tbl%0d_cyc", i), 32'(ifc.o_cycles), 32'(tbl[i].cyc));
    end

    // reset mid-run (state BLK): a blink-mode tick afterwards must reseed, not invert
    reset_pulse();
    ifc.i_mode = 2'd3;
    do_tick(led, wrap, dir);
    check("post_rst_blk_seed", 32'(led), 32'hf);
    check("post_rst_blk_wrap", 32'(wrap), 32'h0);
    ifc.i_mode = 2'd0;
    do_tick(led, wrap, dir);
    check("post_rst_shl_seed", 32'(led), 32'h1);

    // held-high valid: exactly one rotate-right step
    ifc.i_mode = 2'd1;
    do_tick(led, wrap, dir);
    check("shr_seed", 32'(led), 32'h1);
    ifc.i_valid = 1'b1;
    cyc_edge();
    check("held_first_led", 32'(ifc.o_led), 32'h8);
    check("held_first_wrap", 32'(ifc.o_wrap), 32'h1);
    repeat (9) cyc_edge();
    check("held_end_led", 32'(ifc.o_led), 32'h8);
    check("held_end_wrap", 32'(ifc.o_wrap), 32'h0);
    check("held_end_cyc", 32'(ifc.o_cycles), 32'h1);
    ifc.i_valid = 1'b0;
    cyc_edge();

    // disabled: toggling valid changes nothing
    ifc.i_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ifc.i_valid = ~ifc.i_valid;
      cyc_edge();
    end
    ifc.i_valid = 1'b1;
    cyc_edge();
    check("dis_led", 32'(ifc.o_led), 32'h8);
    check("dis_dir", 32'(ifc.o_dir), 32'h0);
    check("dis_wrap", 32'(ifc.o_wrap), 32'h0);
    check("dis_cyc", 32'(ifc.o_cycles), 32'h1);
    // re-enable with valid already high: no tick
    ifc.i_enable = 1'b1;
    repeat (3) cyc_edge();
    check("reen_led", 32'(ifc.o_led), 32'h8);
    ifc.i_valid = 1'b0;
    cyc_edge();

    ifc.i_clr = 1'b1;
    cyc_edge();
    ifc.i_clr = 1'b0;
    check("clr_cyc", 32'(ifc.o_cycles), 32'h0);

    // narrow counter saturation
    reset_pulse();
    ifc.i_mode = 2'd0;
    do_tick(led, wrap, dir);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) do_tick(led, wrap, dir);
      check($sformatf("sat_wrap%0d", w), 32'(wrap), 32'h1);
      check($sformatf("sat_cyc%0d", w), 32'(ifc2.o_cycles), 32'(exp6[w]));
    end
    check("wide_cyc", 32'(ifc.o_cycles), 32'h5);

    // clear coincident with a wrap pulse wins over the increment
    for (int k = 0; k < 3; k++) do_tick(led, wrap, dir);
    ifc.i_valid = 1'b1;
    cyc_edge();
    check("clr_wrap_pulse", 32'(ifc2.o_wrap), 32'h1);
    ifc.i_clr   = 1'b1;
    ifc.i_valid = 1'b0;
    cyc_edge();
    check("clr_vs_wrap", 32'(ifc2.o_cycles), 32'h0);
    ifc.i_clr = 1'b0;
    cyc_edge();
    check("clr_after", 32'(ifc2.o_cycles), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Consumer of the periodic one-cycle `valid` tick produced by the rate counter on the LED board.
- Each detected tick advances an LED pattern: rotate left, rotate right, ping-pong, or blink.
- Flags completion of every full pattern cycle and counts completed cycles.
- Sits between the rate counter's `o_valid` and the board LED pins.

Parameters:
- NB_LEDS, 4, number of LEDs driven; minimum 2.
- NB_CYC, 8, width of the completed-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-low reset. Asserts immediately; release is synchronous to clk.
- i_valid  input  1  rate tick from the counter. Treated as a level; only its rising edge is a tick.
- i_enable  input  1  1 = sequencer runs; 0 = ticks ignored and all state held.
- i_mode  input  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 blink.
- i_clr  input  1  synchronous clear of o_cycles.
- o_led  output  NB_LEDS  LED pattern (registered).
- o_wrap  output  1  one-cycle pulse when a pattern cycle completes (registered).
- o_dir  output  1  current ping-pong direction, 0 = left (toward MSB), 1 = right (registered).
- o_cycles  output  NB_CYC  completed-cycle count, saturating (registered).

Behaviour:
- Reset values:
  - o_led = {0..0,1}, o_wrap = 0, o_dir = 0, o_cycles = 0.
  - Internal valid_q = 0; state = IDLE.
- Tick detection:
  - valid_q registers i_valid every cycle, regardless of i_enable.
  - tick = i_valid & ~valid_q & i_enable.
  - A held-high i_valid yields exactly one tick.
  - o_led, o_dir and o_wrap update on the edge at which tick = 1, i.e. one clock after i_valid rises.
- o_wrap is 0 on every cycle without a tick.
- States: IDLE, SHL, SHR, BNC, BLK. The target state is decoded from i_mode (00 SHL, 01 SHR, 10 BNC, 11 BLK).
- On a tick where state differs from the target (this includes leaving IDLE):
  - state <= target.
  - Load seed: BLK seed = all ones; all other modes seed = {0..0,1}.
  - o_dir <= 0, o_wrap <= 0.
  - No shift happens on this tick.
  - A mode change with no tick takes no effect.
- On a tick where state equals the target:
  - SHL: o_led rotates left by 1. o_wrap = 1 when the MSB wraps into bit 0.
  - SHR: o_led rotates right by 1. o_wrap = 1 when bit 0 wraps into the MSB.
  - BNC, o_dir = 0: shift left. If the result has its MSB set, o_dir <= 1.
  - BNC, o_dir = 1: shift right. If the result equals {0..0,1}, o_dir <= 0 and o_wrap = 1.
  - BNC sequence: period 2*(NB_LEDS-1) ticks. With NB_LEDS = 2 it alternates 01, 10.
  - BLK: o_led <= ~o_led. o_wrap = 1 on the tick producing all ones.
- o_cycles:
  - Increments on the cycle after o_wrap = 1.
  - Saturates at 2^NB_CYC-1; no wrap to 0.
  - i_clr has priority over the increment; o_cycles = 0 on the next edge.
- i_enable = 0:
  - o_led, o_dir, o_cycles and state hold. i_clr is still honoured.
  - On re-enable, an i_valid already high gives no tick because valid_q has tracked it.
- Reset mid-sequence:
  - Outputs return to reset values asynchronously.
  - First tick after release re-seeds from IDLE.
- The only arithmetic is the o_cycles increment, computed NB_CYC bits wide with a saturate compare.

Test Plan:
1. Reset with i_rst = 0 mid-run → o_led = 0001, o_cycles = 0 asynchronously, without waiting for a clock edge. After release, tick 1 with mode 00 reloads 0001 (state IDLE→SHL) with no shift.
2. Mode 00, enable, 5 ticks after seed → o_led 0010, 0100, 1000, 0001 (o_wrap = 1 for one cycle), 0010. o_cycles = 1.
3. Mode 10, 7 ticks after seed → 0010, 0100, 1000 (o_dir→1), 0100, 0010, 0001 (o_wrap, o_dir→0), 0010.
4. i_valid held high 10 cycles, mode 01 → exactly one shift (0001→1000 with o_wrap). Separately, i_valid toggling while i_enable = 0 → no change in any output.
5. Switch mode 00→11 mid-sequence at o_led = 0100 → next tick loads 1111 with o_wrap = 0. Following ticks give 0000, then 1111 with o_wrap = 1.
6. NB_CYC = 2, drive 5 wraps → o_cycles 1, 2, 3, 3, 3. Assert i_clr together with a wrap → o_cycles = 0.
